// File: rtl/image_stream_ctrl_if.sv
// Byte stream bundle between the UART receiver, the image stream controller and the transmitter.
interface image_stream_ctrl_if #(
  parameter int D_BITS = 8
);
  logic [D_BITS-1:0] i_data;
  logic              i_drdy;
  logic              i_tx_rdy;
  logic [D_BITS-1:0] o_data;
  logic              o_dvalid;

  modport master (output i_data, i_drdy, i_tx_rdy, input o_data, o_dvalid);
  modport slave  (input i_data, i_drdy, i_tx_rdy, output o_data, o_dvalid);
endinterface

// File: rtl/image_stream_ctrl.sv
// Parses A5-framed image headers from a UART byte stream, transforms pixel bytes by mode and
// queues them in a small FIFO that drains one byte every other cycle to the transmitter.
//   state   | meaning
//   IDLE    | discard bytes until sync 0xA5
//   HDR     | collect width(2), height(2), mode(1)
//   DATA    | transform and buffer pixel bytes until the pixel count expires
module image_stream_ctrl #(
  parameter int D_BITS       = 8,
  parameter int row_depth    = 1024,
  parameter int column_depth = 1024,
  parameter int CHANNELS     = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int THR          = 128
) (
  input  logic                i_clk,
  input  logic                reset,
  image_stream_ctrl_if.slave  s_if,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_err,
  output logic                o_ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 35;
  localparam logic [16:0]       COL_MAX = 17'(column_depth);
  localparam logic [16:0]       ROW_MAX = 17'(row_depth);
  localparam logic [CNT_W-1:0]  CH_C    = CNT_W'(CHANNELS);
  localparam logic [D_BITS-1:0] THR_C   = D_BITS'(THR);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

  state_t            state_q, state_d;
  logic [2:0]        hdr_cnt_q, hdr_cnt_d;
  logic [15:0]       width_q, width_d;
  logic [15:0]       height_q, height_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [D_BITS-1:0] wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              dvalid_last_q, dvalid_last_d;
  logic [D_BITS-1:0] o_data_q, o_data_d;
  logic [D_BITS-1:0] mem_q [FIFO_DEPTH];

  logic              fifo_empty;
  logic              fifo_full;
  logic              rd_en;
  logic              wr_ok;
  logic              hdr_bad;
  logic [D_BITS-1:0] xf_data;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    rd_en      = !fifo_empty && s_if.i_tx_rdy && !dvalid_last_q;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    wr_ok      = wr_en_q && (!fifo_full || rd_en);
    hdr_bad    = (width_q == 16'd0) || (height_q == 16'd0) ||
                 ({1'b0, width_q} > COL_MAX) || ({1'b0, height_q} > ROW_MAX) ||
                 (s_if.i_data[1:0] == 2'b11);
    case (mode_q)
      2'd1:    xf_data = ~s_if.i_data;
      2'd2:    xf_data = {D_BITS{s_if.i_data >= THR_C}};
      default: xf_data = s_if.i_data;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    width_d       = width_q;
    height_d      = height_q;
    mode_d        = mode_q;
    pix_cnt_d     = pix_cnt_q;
    wr_en_d       = 1'b0;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    err_d         = err_q;
    ovf_d         = ovf_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    dvalid_last_d = rd_en;
    o_data_d      = o_data_q;

    case (state_q)
      ST_IDLE: begin
        if (s_if.i_drdy && (s_if.i_data[7:0] == 8'hA5)) begin
          state_d   = ST_HDR;
          hdr_cnt_d = 3'd0;
        end
      end
      ST_HDR: begin
        if (s_if.i_drdy) begin
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          case (hdr_cnt_q)
            3'd0: width_d[15:8]  = s_if.i_data[7:0];
            3'd1: width_d[7:0]   = s_if.i_data[7:0];
            3'd2: height_d[15:8] = s_if.i_data[7:0];
            3'd3: height_d[7:0]  = s_if.i_data[7:0];
            3'd4: begin
              if (hdr_bad) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end else begin
                mode_d    = s_if.i_data[1:0];
                pix_cnt_d = CNT_W'(width_q) * CNT_W'(height_q) * CH_C;
                state_d   = ST_DATA;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_DATA: begin
        if (s_if.i_drdy) begin
          wr_en_d   = 1'b1;
          wr_data_d = xf_data;
          pix_cnt_d = pix_cnt_q - CNT_W'(1);
          if (pix_cnt_q == CNT_W'(1)) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    else if (wr_en_q) ovf_d = 1'b1;

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      o_data_d = mem_q[rd_ptr_q[PTR_W-1:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      hdr_cnt_q     <= '0;
      width_q       <= '0;
      height_q      <= '0;
      mode_q        <= '0;
      pix_cnt_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      ovf_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      dvalid_last_q <= 1'b0;
      o_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      width_q       <= width_d;
      height_q      <= height_d;
      mode_q        <= mode_d;
      pix_cnt_q     <= pix_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
      ovf_q         <= ovf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      dvalid_last_q <= dvalid_last_d;
      o_data_q      <= o_data_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_q;
  end

  assign s_if.o_dvalid = rd_en;
  assign s_if.o_data   = o_data_d;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_frame_done  = frame_done_q;
  assign o_err         = err_q;
  assign o_ovf         = ovf_q;

endmodule
